// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default widths, ROB depth and the
// reorder-buffer entry layout. The exception bit is only carried when
// ROB_EXCEPTION_EN is defined.
package ooo_pkg;

    localparam int ROB_BITS_C = 4;
    localparam int PR_BITS_C  = 6;
    localparam int AR_BITS_C  = 5;
    localparam int ROB_DEPTH  = 1 << ROB_BITS_C;

    typedef struct packed {
        logic                 valid;
        logic                 done;
`ifdef ROB_EXCEPTION_EN
        logic                 exc;
`endif
        logic                 has_dest;
        logic [AR_BITS_C-1:0] arch_rd;
        logic [PR_BITS_C-1:0] phys_rd;
        logic [PR_BITS_C-1:0] old_phys;
    } rob_entry_t;

    // Circular pointer advance; wraps naturally modulo the depth.
    function automatic logic [ROB_BITS_C-1:0] rob_ptr_next(input logic [ROB_BITS_C-1:0] ptr);
        return ptr + ROB_BITS_C'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order completion tracker. One allocate, one writeback
// and one commit port over a circular buffer of 2^ROB_BITS entries.
// Optional feature macro: ROB_EXCEPTION_EN (adds rob_wb_exc / commit_exc and
// a self-flush on the edge after an excepting head retires).
module reorder_buffer
    import ooo_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_C,
    parameter int PR_BITS  = PR_BITS_C,
    parameter int AR_BITS  = AR_BITS_C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic                alloc_has_dest,
    input  logic [AR_BITS-1:0]  alloc_arch_rd,
    input  logic [PR_BITS-1:0]  alloc_phys_rd,
    input  logic [PR_BITS-1:0]  alloc_old_phys,
    output logic [ROB_BITS-1:0] alloc_idx,
    input  logic                rob_wb_en,
    input  logic [ROB_BITS-1:0] rob_wb_idx,
`ifdef ROB_EXCEPTION_EN
    input  logic                rob_wb_exc,
    output logic                commit_exc,
`endif
    output logic                commit_valid,
    input  logic                commit_ready,
    output logic                commit_has_dest,
    output logic [AR_BITS-1:0]  commit_arch_rd,
    output logic [PR_BITS-1:0]  commit_phys_rd,
    output logic [PR_BITS-1:0]  commit_old_phys,
    input  logic                flush,
    output logic                empty
);

    localparam int              DEPTH      = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0] FULL_COUNT = (ROB_BITS+1)'(DEPTH);
    localparam logic [ROB_BITS:0] CNT_ONE    = (ROB_BITS+1)'(1);

    rob_entry_t          rob_r [DEPTH];
    logic [ROB_BITS-1:0] head_r;
    logic [ROB_BITS-1:0] tail_r;
    logic [ROB_BITS:0]   count_r;
`ifdef ROB_EXCEPTION_EN
    logic                exc_flush_r;
`endif

    rob_entry_t          head_entry_s;
    logic                flush_s;
    logic                do_alloc_s;
    logic                do_commit_s;
    logic                wb_hit_s;

    // Control decode: flush wins over everything, full blocks allocation
    // regardless of a same-cycle commit, writebacks only land on live entries.
    always_comb begin
        head_entry_s = rob_r[head_r];
`ifdef ROB_EXCEPTION_EN
        flush_s      = flush | exc_flush_r;
`else
        flush_s      = flush;
`endif
        if (flush_s) begin
            alloc_ready  = 1'b0;
            commit_valid = 1'b0;
            wb_hit_s     = 1'b0;
        end else begin
            alloc_ready  = (count_r != FULL_COUNT);
            commit_valid = head_entry_s.valid & head_entry_s.done;
            wb_hit_s     = rob_wb_en & rob_r[rob_wb_idx].valid;
        end
        do_alloc_s  = alloc_valid & alloc_ready;
        do_commit_s = commit_valid & commit_ready;
    end

    // Output view: head fields and pointers come straight from registered state.
    always_comb begin
        alloc_idx       = tail_r;
        empty           = (count_r == '0);
        commit_has_dest = head_entry_s.has_dest;
        commit_arch_rd  = head_entry_s.arch_rd;
        commit_phys_rd  = head_entry_s.phys_rd;
        commit_old_phys = head_entry_s.old_phys;
`ifdef ROB_EXCEPTION_EN
        commit_exc      = head_entry_s.exc;
`endif
    end

    // Pointer, occupancy and entry state update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_flush_r <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                rob_r[i] <= '0;
            end
        end else if (flush_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
`ifdef ROB_EXCEPTION_EN
            exc_flush_r <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                rob_r[i].valid <= 1'b0;
                rob_r[i].done  <= 1'b0;
`ifdef ROB_EXCEPTION_EN
                rob_r[i].exc   <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_alloc_s && (tail_r == ROB_BITS'(i))) begin
                    rob_r[i].valid    <= 1'b1;
                    rob_r[i].done     <= 1'b0;
`ifdef ROB_EXCEPTION_EN
                    rob_r[i].exc      <= 1'b0;
`endif
                    rob_r[i].has_dest <= alloc_has_dest;
                    rob_r[i].arch_rd  <= alloc_arch_rd;
                    rob_r[i].phys_rd  <= alloc_phys_rd;
                    rob_r[i].old_phys <= alloc_old_phys;
                end else begin
                    if (wb_hit_s && (rob_wb_idx == ROB_BITS'(i))) begin
                        rob_r[i].done <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                        rob_r[i].exc  <= rob_wb_exc;
`endif
                    end
                    if (do_commit_s && (head_r == ROB_BITS'(i))) begin
                        rob_r[i].valid <= 1'b0;
                    end
                end
            end

            if (do_alloc_s) begin
                tail_r <= rob_ptr_next(tail_r);
            end
            if (do_commit_s) begin
                head_r <= rob_ptr_next(head_r);
            end

            case ({do_alloc_s, do_commit_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase

`ifdef ROB_EXCEPTION_EN
            exc_flush_r <= do_commit_s & head_entry_s.exc;
`endif
        end
    end

endmodule
